// File: rtl/mode_countdown.sv
// mode_countdown: loadable down-counter that drives the mode decoder's
// count input. Supports a load handshake, pause, abort and optional
// auto-reload, and flags terminal count for one cycle.

package mode_countdown_pkg;
   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_RUN     = 2'd1,
      ST_PAUSE   = 2'd2,
      ST_EXPIRED = 2'd3
   } state_t;
endpackage

module mode_countdown
   import mode_countdown_pkg::*;
#(
   parameter int unsigned WIDTH       = 8,
   parameter bit          AUTO_RELOAD = 1'b0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load_valid,
   input  logic [WIDTH-1:0] load_val,
   output logic             load_ready,
   input  logic             pause,
   input  logic             abort,
   output logic [WIDTH-1:0] out,
   output logic             busy,
   output logic             tc,
   output logic [1:0]       state_o
);

   state_t           r_state;
   logic [WIDTH-1:0] r_out;
   logic [WIDTH-1:0] r_reload;
   logic             r_tc;
   logic             r_busy;

   // Count FSM: priority abort > load > pause > count; outputs are registered
   // alongside the state so nothing combinational reaches the ports.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state  <= ST_IDLE;
         r_out    <= '0;
         r_reload <= '0;
         r_tc     <= 1'b0;
         r_busy   <= 1'b0;
      end else if (abort) begin
         r_state  <= ST_IDLE;
         r_out    <= '0;
         r_reload <= '0;
         r_tc     <= 1'b0;
         r_busy   <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               r_tc <= 1'b0;
               if (load_valid) begin
                  r_out    <= load_val;
                  r_reload <= load_val;
                  r_busy   <= 1'b1;
                  if (load_val != '0) begin
                     r_state <= ST_RUN;
                  end else begin
                     r_state <= ST_EXPIRED;
                     r_tc    <= 1'b1;
                  end
               end
            end
            ST_RUN: begin
               if (pause) begin
                  r_state <= ST_PAUSE;
               end else if (r_out <= WIDTH'(1)) begin
                  // Terminal step; the <= guard also keeps a zero count from wrapping.
                  r_out   <= '0;
                  r_state <= ST_EXPIRED;
                  r_tc    <= 1'b1;
               end else begin
                  r_out <= r_out - WIDTH'(1);
               end
            end
            ST_PAUSE: begin
               // Resume edge does not decrement, so no count is lost or doubled.
               if (!pause) begin
                  r_state <= ST_RUN;
               end
            end
            ST_EXPIRED: begin
               r_tc <= 1'b0;
               if (AUTO_RELOAD && (r_reload != '0)) begin
                  r_out   <= r_reload;
                  r_state <= ST_RUN;
               end else begin
                  r_out   <= '0;
                  r_state <= ST_IDLE;
                  r_busy  <= 1'b0;
               end
            end
            default: begin
               r_state <= ST_IDLE;
               r_out   <= '0;
               r_tc    <= 1'b0;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   // Output decode from registered state only.
   always_comb begin
      load_ready = (r_state == ST_IDLE);
      out        = r_out;
      busy       = r_busy;
      tc         = r_tc;
      state_o    = r_state;
   end

endmodule

// File: tb/tb_mode_countdown.sv
// Directed bench for mode_countdown: one instance without auto-reload,
// one with auto-reload; expected values are hand-computed per cycle.

module tb_mode_countdown;

   logic       clk;
   logic       rst;

   logic       a_load_valid, a_pause, a_abort, a_load_ready, a_busy, a_tc;
   logic [7:0] a_load_val, a_out;
   logic [1:0] a_state;

   logic       b_load_valid, b_pause, b_abort, b_load_ready, b_busy, b_tc;
   logic [7:0] b_load_val, b_out;
   logic [1:0] b_state;

   int unsigned n_checks;
   int unsigned n_fail;

   mode_countdown #(.WIDTH(8), .AUTO_RELOAD(1'b0)) u_dut_a (
      .clk(clk), .rst(rst),
      .load_valid(a_load_valid), .load_val(a_load_val), .load_ready(a_load_ready),
      .pause(a_pause), .abort(a_abort),
      .out(a_out), .busy(a_busy), .tc(a_tc), .state_o(a_state)
   );

   mode_countdown #(.WIDTH(8), .AUTO_RELOAD(1'b1)) u_dut_b (
      .clk(clk), .rst(rst),
      .load_valid(b_load_valid), .load_val(b_load_val), .load_ready(b_load_ready),
      .pause(b_pause), .abort(b_abort),
      .out(b_out), .busy(b_busy), .tc(b_tc), .state_o(b_state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // out, state, tc, busy, load_ready and decoder mode (1 = start) of instance A
   task automatic exp_a(input string tag, input int o, input int s, input int t, input int b);
      check({tag, ".out"}, 32'(a_out), 32'(o));
      check({tag, ".st"}, 32'(a_state), 32'(s));
      check({tag, ".tc"}, 32'(a_tc), 32'(t));
      check({tag, ".busy"}, 32'(a_busy), 32'(b));
      check({tag, ".rdy"}, 32'(a_load_ready), 32'(s == 0));
      check({tag, ".start"}, 32'(a_out == 8'd0), 32'(o == 0));
   endtask

   task automatic exp_b(input string tag, input int o, input int s, input int t);
      check({tag, ".out"}, 32'(b_out), 32'(o));
      check({tag, ".st"}, 32'(b_state), 32'(s));
      check({tag, ".tc"}, 32'(b_tc), 32'(t));
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      rst = 1'b1;
      a_load_valid = 1'b0; a_load_val = '0; a_pause = 1'b0; a_abort = 1'b0;
      b_load_valid = 1'b0; b_load_val = '0; b_pause = 1'b0; b_abort = 1'b0;
      #12;
      exp_a("rst", 0, 0, 0, 0);
      exp_b("rst_b", 0, 0, 0);
      rst = 1'b0;
      tick();

      // 1: load 3, count to terminal
      a_load_valid = 1'b1; a_load_val = 8'd3;
      tick();
      a_load_valid = 1'b0;
      exp_a("t1.c0", 3, 1, 0, 1);
      tick(); exp_a("t1.c1", 2, 1, 0, 1);
      tick(); exp_a("t1.c2", 1, 1, 0, 1);
      tick(); exp_a("t1.c3", 0, 3, 1, 1);
      tick(); exp_a("t1.c4", 0, 0, 0, 0);

      // 2: load 0 goes straight to EXPIRED; pause ignored in IDLE and EXPIRED
      a_load_valid = 1'b1; a_load_val = 8'd0; a_pause = 1'b1;
      tick();
      a_load_valid = 1'b0;
      exp_a("t2.c0", 0, 3, 1, 1);
      tick(); exp_a("t2.c1", 0, 0, 0, 0);
      a_pause = 1'b0;
      tick(); exp_a("t2.c2", 0, 0, 0, 0);

      // 3: load 8, pause at 5 for three edges; terminal 12 edges after load
      a_load_valid = 1'b1; a_load_val = 8'd8;
      tick();
      a_load_valid = 1'b0;
      exp_a("t3.l", 8, 1, 0, 1);
      tick(); tick(); tick();
      exp_a("t3.r5", 5, 1, 0, 1);
      a_pause = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick(); exp_a("t3.p", 5, 2, 0, 1);
      end
      a_pause = 1'b0;
      tick(); exp_a("t3.res", 5, 1, 0, 1);
      for (int v = 4; v >= 1; v--) begin
         tick(); exp_a("t3.dn", v, 1, 0, 1);
      end
      tick(); exp_a("t3.tc", 0, 3, 1, 1);
      tick(); exp_a("t3.idle", 0, 0, 0, 0);

      // 4: load 6, load attempt during RUN ignored, abort at 2
      a_load_valid = 1'b1; a_load_val = 8'd6;
      tick();
      exp_a("t4.l", 6, 1, 0, 1);
      a_load_val = 8'd9;
      tick(); exp_a("t4.ign5", 5, 1, 0, 1);
      tick(); exp_a("t4.ign4", 4, 1, 0, 1);
      tick(); exp_a("t4.ign3", 3, 1, 0, 1);
      a_load_valid = 1'b0;
      tick(); exp_a("t4.r2", 2, 1, 0, 1);
      a_abort = 1'b1;
      tick(); exp_a("t4.ab", 0, 0, 0, 0);
      a_abort = 1'b0;
      tick(); exp_a("t4.post", 0, 0, 0, 0);
      // abort beats load in IDLE
      a_abort = 1'b1; a_load_valid = 1'b1; a_load_val = 8'd5;
      tick(); exp_a("t4.abld", 0, 0, 0, 0);
      a_abort = 1'b0; a_load_valid = 1'b0;
      tick(); exp_a("t4.abld2", 0, 0, 0, 0);

      // 5: auto-reload instance, load 2
      b_load_valid = 1'b1; b_load_val = 8'd2;
      tick();
      b_load_valid = 1'b0;
      exp_b("t5.c0", 2, 1, 0);
      tick(); exp_b("t5.c1", 1, 1, 0);
      tick(); exp_b("t5.c2", 0, 3, 1);
      tick(); exp_b("t5.c3", 2, 1, 0);
      tick(); exp_b("t5.c4", 1, 1, 0);
      tick(); exp_b("t5.c5", 0, 3, 1);
      tick(); exp_b("t5.c6", 2, 1, 0);
      b_abort = 1'b1;
      tick(); exp_b("t5.ab", 0, 0, 0);
      b_abort = 1'b0;
      tick(); exp_b("t5.post", 0, 0, 0);
      tick(); exp_b("t5.post2", 0, 0, 0);
      check("t5.rdy", 32'(b_load_ready), 32'd1);

      // 6: async reset mid-count at 100
      a_load_valid = 1'b1; a_load_val = 8'd150;
      tick();
      a_load_valid = 1'b0;
      for (int i = 0; i < 50; i++) tick();
      exp_a("t6.pre", 100, 1, 0, 1);
      #2 rst = 1'b1;
      #1;
      exp_a("t6.async", 0, 0, 0, 0);
      #1 rst = 1'b0;
      a_load_valid = 1'b1; a_load_val = 8'd1;
      tick();
      a_load_valid = 1'b0;
      exp_a("t6.l1", 1, 1, 0, 1);
      tick(); exp_a("t6.tc", 0, 3, 1, 1);
      tick(); exp_a("t6.idle", 0, 0, 0, 0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
